axi_burst_scheduler: RTL and testbench
======================================

Name: axi_burst_scheduler

Overview:
- Shares one AXI_memory_master_burst instance between NUM_REQ requesters, e.g. frame writer and frame reader.
- Round-robin arbitration over burst requests.
- Drives the master's start_write/start_read control inputs.
- Snoops the AXI handshakes to detect address acceptance and burst completion, then returns a per-requester done pulse.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, address width.
- DEF_SIZE, 3'b010, AxSIZE driven on write_size/read_size (4-byte beats).
- DEF_BURST, 2'b01, AxBURST driven on write_burst/read_burst (INCR).
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level; held until done
- req_write  in  NUM_REQ  1=write burst, 0=read burst
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed start addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_len  in  NUM_REQ*8  packed beat counts minus 1 (AXI len encoding)
- grant  out  NUM_REQ  one-hot owner of the master; 0 when idle
- done  out  NUM_REQ  one-cycle completion pulse to the owner
- err  out  1  one-cycle pulse, coincident with done, on watchdog abort
- busy  out  1  high in any state other than IDLE
- start_write  out  1  to master
- start_read  out  1  to master
- write_addr / read_addr  out  ADDR_WIDTH  to master
- write_len / read_len  out  32  zero-extended req_len of the owner
- write_size / read_size  out  3  DEF_SIZE
- write_burst / read_burst  out  2  DEF_BURST
- awvalid, awready, arvalid, arready, bvalid, bready, rvalid, rready, rlast  in  1 each  snooped AXI handshakes

Behaviour:
- Clock clk; reset synchronous, active-high.
- Reset values:
  - grant=0, done=0, err=0, busy=0
  - start_write=0, start_read=0
  - addr/len outputs=0
  - size/burst outputs = DEF_SIZE/DEF_BURST
  - rr_ptr=NUM_REQ-1
  - state=IDLE
- Reset asserted mid-transaction aborts immediately. No done is generated and all outputs return to reset values next edge.
- States:
  - IDLE: if any req bit set, select the first set bit scanning upward from rr_ptr+1 modulo NUM_REQ. Register grant (one-hot), latch that requester's addr/len/write into output registers, set rr_ptr to the winner, go to ISSUE. Grant appears 1 cycle after req is sampled.
  - ISSUE: assert start_write (if write) or start_read (if read); the other start stays 0. Hold until awvalid&awready (write) or arvalid&arready (read) is sampled. On that edge drop start and go to WAIT_RESP.
  - WAIT_RESP:
    - Write completes on bvalid&bready.
    - Read completes on rvalid&rready&rlast.
    - On the completion edge go to DONE.
  - DONE: done[owner]=1 for exactly this cycle, grant still held. Next edge: grant=0, state=IDLE.
- Minimum gap between consecutive grants: 1 idle cycle (DONE->IDLE->ISSUE).
- Output registers are stable from grant until grant falls; later changes to req_addr/req_len are ignored.
- A requester that deasserts req while granted does not cancel the transaction; done still pulses.
- Simultaneous requests: round-robin guarantees each active requester is granted within NUM_REQ transactions.
- Requests arriving during a transaction wait; they are evaluated only in IDLE.
- A completion handshake seen in ISSUE is ignored, because the address handshake must precede it.
- req_len=0 (single beat) is legal.

Optional Feature:
- Macro: AXI_BURST_SCHED_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT_RESP.
  - On reaching TIMEOUT_CYCLES: drop start, go to DONE, and pulse err with done.
  - rr_ptr still advances.
- Not defined: no counter is built, err is tied 0, and the scheduler waits indefinitely.

Test Plan:
- Reset held 3 cycles with req=2'b11 -> grant=0, start_write=start_read=0, busy=0; after release, first grant=2'b01 (rr_ptr starts at 1).
- req[0] write, addr 0x0, len 7; slave gives awready 1 cycle after awvalid, 8 beats, bvalid -> start_write high until the aw handshake, write_len=7, done[0] one cycle after bvalid&bready, grant back to 0 the next cycle.
- req[1] read, addr 0x0, len 7 -> start_read only; done[1] exactly 1 cycle after the rvalid&rready&rlast edge; no done on the 7 earlier beats.
- req=2'b11 held continuously for 4 transactions -> grant order 01,10,01,10, each separated by one IDLE cycle.
- req[0] drops and req_addr[0] changes to 0x40 after grant -> write_addr stays 0x0 and done[0] still pulses.
- With AXI_BURST_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never raises bvalid -> done[0] and err pulse together in cycle 17 after ISSUE entry, then IDLE; without the macro the bench sees busy remain 1 and err=0.

Source files
------------

// File: rtl/axi_burst_scheduler.sv
// Round-robin scheduler sharing one AXI burst master between NUM_REQ requesters.
// Optional watchdog abort enabled by defining AXI_BURST_SCHED_TIMEOUT_EN.
module axi_burst_scheduler #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter logic [2:0]  DEF_SIZE       = 3'b010,
    parameter logic [1:0]  DEF_BURST      = 2'b01,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]          req_len,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            done,
    output logic                          err,
    output logic                          busy,
    output logic                          start_write,
    output logic                          start_read,
    output logic [ADDR_WIDTH-1:0]         write_addr,
    output logic [ADDR_WIDTH-1:0]         read_addr,
    output logic [31:0]                   write_len,
    output logic [31:0]                   read_len,
    output logic [2:0]                    write_size,
    output logic [2:0]                    read_size,
    output logic [1:0]                    write_burst,
    output logic [1:0]                    read_burst,
    input  logic                          awvalid,
    input  logic                          awready,
    input  logic                          arvalid,
    input  logic                          arready,
    input  logic                          bvalid,
    input  logic                          bready,
    input  logic                          rvalid,
    input  logic                          rready,
    input  logic                          rlast
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic               owner_write;
    logic               found;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   cand;
    logic [NUM_REQ-1:0] win_onehot;
    logic               addr_hs;
    logic               resp_hs;

    // Scan upward from rr_ptr+1; the winner becomes the new rr_ptr, so rr_ptr also names the owner.
    always_comb begin
        found = 1'b0;
        win   = rr_ptr;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        win_onehot = NUM_REQ'(1) << win;
    end

    assign addr_hs = owner_write ? (awvalid & awready) : (arvalid & arready);
    assign resp_hs = owner_write ? (bvalid & bready) : (rvalid & rready & rlast);

    assign busy        = (state != S_IDLE);
    assign write_size  = DEF_SIZE;
    assign read_size   = DEF_SIZE;
    assign write_burst = DEF_BURST;
    assign read_burst  = DEF_BURST;

`ifdef AXI_BURST_SCHED_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        timed_out;

    assign timed_out = ((state == S_ISSUE) || (state == S_WAIT && !resp_hs)) &&
                       (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign err            = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            rr_ptr      <= PTR_W'(NUM_REQ - 1);
            owner_write <= 1'b0;
            grant       <= '0;
            done        <= '0;
            start_write <= 1'b0;
            start_read  <= 1'b0;
            write_addr  <= '0;
            read_addr   <= '0;
            write_len   <= '0;
            read_len    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant       <= win_onehot;
                        rr_ptr      <= win;
                        owner_write <= req_write[win];
                        start_write <= req_write[win];
                        start_read  <= !req_write[win];
                        write_addr  <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                        read_addr   <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                        write_len   <= {24'd0, req_len[win*8 +: 8]};
                        read_len    <= {24'd0, req_len[win*8 +: 8]};
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (addr_hs) begin
                        start_write <= 1'b0;
                        start_read  <= 1'b0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (resp_hs) begin
                        done  <= grant;
                        state <= S_DONE;
                    end
                end
                default: begin
                    done  <= '0;
                    grant <= '0;
                    state <= S_IDLE;
                end
            endcase
`ifdef AXI_BURST_SCHED_TIMEOUT_EN
            // Watchdog overrides the case above; a genuine completion on the same edge wins.
            if (timed_out) begin
                start_write <= 1'b0;
                start_read  <= 1'b0;
                done        <= grant;
                state       <= S_DONE;
            end
`endif
        end
    end

`ifdef AXI_BURST_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                wd_cnt <= '0;
            end else if (state == S_ISSUE || state == S_WAIT) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            err <= timed_out;
        end
    end
`endif

endmodule

// File: tb/tb_axi_burst_scheduler.sv
// Self-checking bench for axi_burst_scheduler; the bench plays both the AXI master and slave.
// Builds with or without AXI_BURST_SCHED_TIMEOUT_EN.
module tb_axi_burst_scheduler;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 32;
    localparam logic [2:0]  DSZ = 3'b010;
    localparam logic [1:0]  DBU = 2'b01;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*8-1:0]  req_len = '0;
    logic [N-1:0]  grant, done;
    logic          err, busy, start_write, start_read;
    logic [AW-1:0] write_addr, read_addr;
    logic [31:0]   write_len, read_len;
    logic [2:0]    write_size, read_size;
    logic [1:0]    write_burst, read_burst;
    logic awvalid = 1'b0, awready = 1'b0, arvalid = 1'b0, arready = 1'b0;
    logic bvalid = 1'b0, bready = 1'b0, rvalid = 1'b0, rready = 1'b0, rlast = 1'b0;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    int unsigned last_win = N - 1;

    always #5 clk = ~clk;

    axi_burst_scheduler #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DEF_SIZE(DSZ), .DEF_BURST(DBU), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_write(req_write), .req_addr(req_addr),
        .req_len(req_len), .grant(grant), .done(done), .err(err), .busy(busy),
        .start_write(start_write), .start_read(start_read),
        .write_addr(write_addr), .read_addr(read_addr), .write_len(write_len), .read_len(read_len),
        .write_size(write_size), .read_size(read_size), .write_burst(write_burst), .read_burst(read_burst),
        .awvalid(awvalid), .awready(awready), .arvalid(arvalid), .arready(arready),
        .bvalid(bvalid), .bready(bready), .rvalid(rvalid), .rready(rready), .rlast(rlast)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first pending requester after the previous winner, wrapping.
    function automatic int unsigned rr_pick(input int unsigned last, input logic [N-1:0] r);
        int unsigned c;
        for (int unsigned k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (r[c]) return c;
        end
        return last;
    endfunction

    function automatic logic [N-1:0] onehot(input int unsigned i);
        return N'(1) << i;
    endfunction

    // Called on the first cycle grant is visible; runs the address phase, the data phase and
    // the DONE cycle, then returns in the following IDLE cycle. mode: 0 release req at done,
    // 1 drop req right after grant, 2 keep req, 3 clear every req at done.
    task automatic drive_txn(input int unsigned w, input bit is_wr, input int unsigned len,
                             input int unsigned aw_lat, input int unsigned mode, input bit chg_addr,
                             output bit start_ok, output bit addr_ok, output bit stray_done,
                             output logic [N-1:0] done_obs, output logic err_obs,
                             output logic [N-1:0] grant_after, output logic busy_after);
        logic [AW-1:0] a0;
        logic [31:0]   l0;
        a0 = is_wr ? write_addr : read_addr;
        l0 = is_wr ? write_len : read_len;
        start_ok   = (start_write === is_wr) && (start_read === !is_wr);
        addr_ok    = 1'b1;
        stray_done = 1'b0;
        if (mode == 1) req[w] = 1'b0;
        if (chg_addr) begin
            req_addr[w*AW +: AW] = 32'h40;
            req_len[w*8 +: 8]    = 8'hff;
        end
        if (is_wr) awvalid = 1'b1; else arvalid = 1'b1;
        for (int unsigned c = 0; c < aw_lat; c++) begin
            // A completion handshake before the address handshake must be ignored.
            if (c == 0) begin bvalid = 1; bready = 1; rvalid = 1; rready = 1; rlast = 1; end
            tick;
            bvalid = 0; bready = 0; rvalid = 0; rready = 0; rlast = 0;
            start_ok   &= (start_write === is_wr) && (start_read === !is_wr);
            stray_done |= (done !== '0);
        end
        if (is_wr) awready = 1'b1; else arready = 1'b1;
        tick;
        awvalid = 0; awready = 0; arvalid = 0; arready = 0;
        start_ok   &= (start_write === 1'b0) && (start_read === 1'b0);
        stray_done |= (done !== '0);
        if (is_wr) begin
            for (int unsigned c = 0; c < len + 1 + $urandom_range(0, 2); c++) begin
                bvalid = 1'($urandom_range(0, 1));
                tick;
                stray_done |= (done !== '0);
            end
            bvalid = 1; bready = 1;
            tick;
        end else begin
            for (int unsigned b = 0; b <= len; b++) begin
                if (len < 4 && $urandom_range(0, 1) == 1) begin
                    rvalid = 0; rready = 1;
                    tick;
                    stray_done |= (done !== '0);
                end
                rvalid = 1; rready = 1; rlast = (b == len);
                tick;
                if (b < len) stray_done |= (done !== '0);
            end
        end
        done_obs = done;
        err_obs  = err;
        bvalid = 0; bready = 0; rvalid = 0; rready = 0; rlast = 0;
        addr_ok &= ((is_wr ? write_addr : read_addr) === a0) && ((is_wr ? write_len : read_len) === l0);
        if (mode == 0) req[w] = 1'b0;
        if (mode == 3) req = '0;
        tick;
        grant_after = grant;
        busy_after  = busy;
        stray_done |= (done !== '0);
    endtask

    task automatic test_reset;
        bit so, ao, sd; logic [N-1:0] d, g; logic e, b; int unsigned exp;
        req = 2'b11; req_write = 2'b01; req_addr = {32'h200, 32'h100}; req_len = {8'd2, 8'd1};
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            total_cnt++;
            if ({grant, done, err, busy, start_write, start_read} !== '0)
                $display("FAIL reset_ctrl: got grant=%b done=%b err=%b busy=%b sw=%b sr=%b want all 0",
                         grant, done, err, busy, start_write, start_read);
            else pass_cnt++;
            total_cnt++;
            if ({write_addr, read_addr, write_len, read_len} !== '0 ||
                {write_size, read_size, write_burst, read_burst} !== {DSZ, DSZ, DBU, DBU})
                $display("FAIL reset_data: got wa=%h ra=%h wl=%0d rl=%0d sz=%b/%b bu=%b/%b",
                         write_addr, read_addr, write_len, read_len, write_size, read_size, write_burst, read_burst);
            else pass_cnt++;
        end
        reset = 1'b0;
        for (int t = 0; t < 2; t++) begin
            tick;
            exp = rr_pick(last_win, req);
            total_cnt++;
            if (grant !== onehot(exp)) $display("FAIL reset_grant%0d: got %b want %b", t, grant, onehot(exp));
            else pass_cnt++;
            drive_txn(exp, req_write[exp], req_len[exp*8 +: 8], 1, 0, 0, so, ao, sd, d, e, g, b);
            total_cnt++;
            if ({so, sd, d, e, g, b} !== {1'b1, 1'b0, onehot(exp), 1'b0, {N{1'b0}}, 1'b0})
                $display("FAIL reset_txn%0d: got start_ok=%b stray=%b done=%b err=%b grant_after=%b busy_after=%b",
                         t, so, sd, d, e, g, b);
            else pass_cnt++;
            last_win = exp;
        end
    endtask

    task automatic test_write_burst;
        bit so, ao, sd; logic [N-1:0] d, g; logic e, b;
        req_write[0] = 1'b1; req_addr[31:0] = 32'h0; req_len[7:0] = 8'd7; req = 2'b01;
        tick;
        total_cnt++;
        if (grant !== 2'b01) $display("FAIL wr_grant: got %b want 01", grant); else pass_cnt++;
        total_cnt++;
        if (write_addr !== 32'h0 || write_len !== 32'd7)
            $display("FAIL wr_addr_len: got %h/%0d want 0/7", write_addr, write_len);
        else pass_cnt++;
        drive_txn(0, 1'b1, 7, 1, 0, 0, so, ao, sd, d, e, g, b);
        total_cnt++;
        if (!so || sd) $display("FAIL wr_start: got start_ok=%b stray_done=%b want 1/0", so, sd); else pass_cnt++;
        total_cnt++;
        if (d !== 2'b01 || e !== 1'b0) $display("FAIL wr_done: got %b err=%b want 01 err=0", d, e); else pass_cnt++;
        total_cnt++;
        if (g !== 2'b00 || b !== 1'b0) $display("FAIL wr_release: got grant=%b busy=%b want 00/0", g, b); else pass_cnt++;
        last_win = 0;
    endtask

    task automatic test_read_burst;
        bit so, ao, sd; logic [N-1:0] d, g; logic e, b;
        req_write[1] = 1'b0; req_addr[63:32] = 32'h0; req_len[15:8] = 8'd7; req = 2'b10;
        tick;
        total_cnt++;
        if (grant !== 2'b10 || read_len !== 32'd7 || read_addr !== 32'h0)
            $display("FAIL rd_grant: got grant=%b len=%0d addr=%h want 10/7/0", grant, read_len, read_addr);
        else pass_cnt++;
        drive_txn(1, 1'b0, 7, 2, 0, 0, so, ao, sd, d, e, g, b);
        total_cnt++;
        if (!so || sd) $display("FAIL rd_start: got start_ok=%b stray_done=%b want 1/0", so, sd); else pass_cnt++;
        total_cnt++;
        if (d !== 2'b10 || e !== 1'b0 || g !== 2'b00)
            $display("FAIL rd_done: got done=%b err=%b grant_after=%b want 10/0/00", d, e, g);
        else pass_cnt++;
        last_win = 1;
    endtask

    task automatic test_round_robin;
        bit so, ao, sd; logic [N-1:0] d, g; logic e, b; int unsigned exp;
        for (int unsigned i = 0; i < N; i++) begin
            req_write[i] = 1'($urandom_range(0, 1));
            req_addr[i*AW +: AW] = $urandom;
            req_len[i*8 +: 8] = 8'($urandom_range(0, 7));
        end
        req = '1;
        for (int t = 0; t < 4; t++) begin
            tick;
            exp = rr_pick(last_win, req);
            total_cnt++;
            if (grant !== onehot(exp)) $display("FAIL rr_grant%0d: got %b want %b", t, grant, onehot(exp));
            else pass_cnt++;
            drive_txn(exp, req_write[exp], req_len[exp*8 +: 8], $urandom_range(0, 2), (t == 3) ? 3 : 2, 0,
                      so, ao, sd, d, e, g, b);
            total_cnt++;
            if ({so, sd, d, g, b} !== {1'b1, 1'b0, onehot(exp), {N{1'b0}}, 1'b0})
                $display("FAIL rr_txn%0d: got start_ok=%b stray=%b done=%b grant_after=%b busy_after=%b",
                         t, so, sd, d, g, b);
            else pass_cnt++;
            last_win = exp;
        end
    endtask

    task automatic test_hold_addr;
        bit so, ao, sd; logic [N-1:0] d, g; logic e, b;
        req_write[0] = 1'b1; req_addr[31:0] = 32'h0; req_len[7:0] = 8'd3; req = 2'b01;
        tick;
        total_cnt++;
        if (grant !== onehot(rr_pick(last_win, 2'b01))) $display("FAIL hold_grant: got %b want 01", grant);
        else pass_cnt++;
        drive_txn(0, 1'b1, 3, 2, 1, 1, so, ao, sd, d, e, g, b);
        total_cnt++;
        if (!ao || write_addr !== 32'h0)
            $display("FAIL hold_addr: got stable=%b write_addr=%h want 1/0", ao, write_addr);
        else pass_cnt++;
        total_cnt++;
        if (d !== 2'b01 || sd) $display("FAIL hold_done: got done=%b stray=%b want 01/0", d, sd); else pass_cnt++;
        last_win = 0;
        req_addr[31:0] = 32'h0;
    endtask

    task automatic test_random;
        bit so, ao, sd; logic [N-1:0] d, g; logic e, b; int unsigned exp;
        logic [AW-1:0] ea; logic [7:0] el;
        for (int t = 0; t < 25; t++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    req_write[i] = 1'($urandom_range(0, 1));
                    req_addr[i*AW +: AW] = $urandom;
                    req_len[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 7));
                    req[i] = 1'b1;
                end
            end
            if (req == '0) begin
                exp = $urandom_range(0, N - 1);
                req_len[exp*8 +: 8] = 8'($urandom_range(0, 7));
                req[exp] = 1'b1;
            end
            exp = rr_pick(last_win, req);
            ea = req_addr[exp*AW +: AW];
            el = req_len[exp*8 +: 8];
            tick;
            total_cnt++;
            if (grant !== onehot(exp)) $display("FAIL rnd_grant%0d: got %b want %b", t, grant, onehot(exp));
            else pass_cnt++;
            total_cnt++;
            if ((req_write[exp] ? write_addr : read_addr) !== ea || (req_write[exp] ? write_len : read_len) !== {24'd0, el})
                $display("FAIL rnd_addr%0d: got wa=%h ra=%h wl=%0d rl=%0d want %h/%0d",
                         t, write_addr, read_addr, write_len, read_len, ea, el);
            else pass_cnt++;
            drive_txn(exp, req_write[exp], el, $urandom_range(0, 3), $urandom_range(0, 1),
                      1'($urandom_range(0, 1)), so, ao, sd, d, e, g, b);
            total_cnt++;
            if ({so, ao, sd, d, e, g, b} !== {1'b1, 1'b1, 1'b0, onehot(exp), 1'b0, {N{1'b0}}, 1'b0})
                $display("FAIL rnd_txn%0d: got start_ok=%b stable=%b stray=%b done=%b err=%b grant_after=%b busy_after=%b",
                         t, so, ao, sd, d, e, g, b);
            else pass_cnt++;
            last_win = exp;
        end
        req = '0;
        tick;
    endtask

    task automatic test_timeout;
        bit early;
        req_write[0] = 1'b1; req_len[7:0] = 8'd0; req = 2'b01;
        tick;
        total_cnt++;
        if (grant !== onehot(rr_pick(last_win, 2'b01))) $display("FAIL to_grant: got %b want 01", grant);
        else pass_cnt++;
        last_win = 0;
        awvalid = 1; awready = 1;
        tick;
        awvalid = 0; awready = 0;
        early = 1'b0;
`ifdef AXI_BURST_SCHED_TIMEOUT_EN
        for (int k = 2; k <= 16; k++) begin
            early |= (done !== '0) || (err !== 1'b0);
            tick;
        end
        total_cnt++;
        if (early) $display("FAIL to_early: done/err before cycle 17"); else pass_cnt++;
        total_cnt++;
        if (done !== 2'b01 || err !== 1'b1 || start_write !== 1'b0)
            $display("FAIL to_abort: got done=%b err=%b sw=%b want 01/1/0", done, err, start_write);
        else pass_cnt++;
        req = '0;
        tick;
        total_cnt++;
        if (busy !== 1'b0 || grant !== 2'b00 || err !== 1'b0 || done !== 2'b00)
            $display("FAIL to_idle: got busy=%b grant=%b err=%b done=%b want 0/00/0/00", busy, grant, err, done);
        else pass_cnt++;
`else
        for (int k = 0; k < 40; k++) begin
            early |= (busy !== 1'b1) || (err !== 1'b0) || (done !== '0);
            tick;
        end
        total_cnt++;
        if (early) $display("FAIL to_wait: got busy=%b err=%b done=%b want busy held, no err/done", busy, err, done);
        else pass_cnt++;
        req = '0;
`endif
    endtask

    task automatic test_reset_abort;
        bit so, ao, sd; logic [N-1:0] d, g; logic e, b;
        if (!busy) begin
            req_write[1] = 1'b0; req_addr[63:32] = 32'h80; req_len[15:8] = 8'd3; req = 2'b10;
            tick;
            total_cnt++;
            if (grant !== onehot(rr_pick(last_win, 2'b10))) $display("FAIL abort_grant: got %b want 10", grant);
            else pass_cnt++;
            arvalid = 1; arready = 1;
            tick;
            arvalid = 0; arready = 0;
            tick;
        end
        reset = 1'b1; req = '0;
        rvalid = 1; rready = 1; rlast = 1;
        tick;
        rvalid = 0; rready = 0; rlast = 0;
        total_cnt++;
        if ({grant, done, err, busy, start_write, start_read, write_addr, read_addr, write_len, read_len} !== '0)
            $display("FAIL abort_reset: got grant=%b done=%b err=%b busy=%b sw=%b sr=%b ra=%h rl=%0d want all 0",
                     grant, done, err, busy, start_write, start_read, read_addr, read_len);
        else pass_cnt++;
        reset = 1'b0;
        tick;
        total_cnt++;
        if (done !== '0 || busy !== 1'b0) $display("FAIL abort_nodone: got done=%b busy=%b want 00/0", done, busy);
        else pass_cnt++;
        last_win = N - 1;
        req_write = '0; req_len = '0; req = '1;
        tick;
        total_cnt++;
        if (grant !== onehot(rr_pick(last_win, req))) $display("FAIL abort_rrptr: got %b want 01", grant);
        else pass_cnt++;
        drive_txn(0, 1'b0, 0, 1, 3, 0, so, ao, sd, d, e, g, b);
        total_cnt++;
        if (d !== 2'b01 || sd || g !== 2'b00) $display("FAIL abort_txn: got done=%b stray=%b grant_after=%b", d, sd, g);
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_write_burst;
        test_read_burst;
        test_round_robin;
        test_hold_addr;
        test_random;
        test_timeout;
        test_reset_abort;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
